// File: rtl/ir_pc_next_pkg.sv
// rtl/ir_pc_next_pkg.sv - shared PC-source codes and instruction field positions
package ir_pc_next_pkg;

  localparam logic [1:0] PCSRC_A      = 2'b00;
  localparam logic [1:0] PCSRC_ALURES = 2'b01;
  localparam logic [1:0] PCSRC_ALU    = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam int WORD_W    = 32;
  localparam int REG_W     = 5;
  localparam int IMM_W     = 16;
  localparam int IMM_LSB   = 0;
  localparam int RD_LSB    = 11;
  localparam int RT_LSB    = 16;
  localparam int RS_LSB    = 21;
  localparam int JIDX_W    = 26;
  localparam int PC_HI_LSB = 28;
  localparam int PC_HI_W   = 4;

endpackage

// File: rtl/ir_pc_next_if.sv
// rtl/ir_pc_next_if.sv - control/data bundle between the sequencer and the next-PC slice
interface ir_pc_next_if;
  import ir_pc_next_pkg::*;

  logic              ir_we;
  logic              pc_wren;
  logic [1:0]        control_signal;
  logic [WORD_W-1:0] pc_in;
  logic [WORD_W-1:0] instr_in;
  logic [WORD_W-1:0] a_in;
  logic [WORD_W-1:0] alu_res_in;
  logic [WORD_W-1:0] alu_in;
  logic [WORD_W-1:0] instr_out;
  logic [IMM_W-1:0]  imm16;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rs;
  logic [WORD_W-1:0] output_word;

  modport master (
    output ir_we, pc_wren, control_signal, pc_in, instr_in, a_in, alu_res_in, alu_in,
    input  instr_out, imm16, rd, rt, rs, output_word
  );

  modport slave (
    input  ir_we, pc_wren, control_signal, pc_in, instr_in, a_in, alu_res_in, alu_in,
    output instr_out, imm16, rd, rt, rs, output_word
  );
endinterface

// File: rtl/concat.sv
// rtl/concat.sv - J-type jump target from PC region bits and the 26-bit word index
module concat
  import ir_pc_next_pkg::*;
(
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] jump_target
);

  // Only the PC region and the word index participate; the rest is routed nowhere.
  logic unused_bits;
  assign unused_bits = &{1'b0, pc_in[PC_HI_LSB-1:0], instr[WORD_W-1:JIDX_W]};

  assign jump_target = {pc_in[PC_HI_LSB +: PC_HI_W], instr[JIDX_W-1:0], 2'b00};

endmodule

// File: rtl/instruction_register.sv
// rtl/instruction_register.sv - enabled instruction latch with register/immediate field decode
module instruction_register
  import ir_pc_next_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [WORD_W-1:0] instr_in,
  output logic [WORD_W-1:0] instr_out,
  output logic [IMM_W-1:0]  imm16,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rt,
  output logic [REG_W-1:0]  rs
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out <= '0;
    end else if (we) begin
      instr_out <= instr_in;
    end
  end

  assign imm16 = instr_out[IMM_LSB +: IMM_W];
  assign rd    = instr_out[RD_LSB  +: REG_W];
  assign rt    = instr_out[RT_LSB  +: REG_W];
  assign rs    = instr_out[RS_LSB  +: REG_W];

endmodule

// File: rtl/mux_pc_src.sv
// rtl/mux_pc_src.sv - 4:1 next-PC source selector
module mux_pc_src
  import ir_pc_next_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] alu_res_in,
  input  logic [WORD_W-1:0] alu_in,
  input  logic [WORD_W-1:0] jump_target,
  output logic [WORD_W-1:0] mux_out
);

  always_comb begin
    unique case (sel)
      PCSRC_A:      mux_out = a_in;
      PCSRC_ALURES: mux_out = alu_res_in;
      PCSRC_ALU:    mux_out = alu_in;
      PCSRC_JUMP:   mux_out = jump_target;
    endcase
  end

endmodule

// File: rtl/pc_register.sv
// rtl/pc_register.sv - 32-bit program counter with write enable and async clear
module pc_register
  import ir_pc_next_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ir_pc_next.sv
// rtl/ir_pc_next.sv - next-PC slice: IR, jump concat, PC-source mux and PC register
module ir_pc_next
  import ir_pc_next_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  ir_pc_next_if.slave  bus
);

  logic [WORD_W-1:0] jump_target;
  logic [WORD_W-1:0] next_pc;

  instruction_register u_ir (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (bus.ir_we),
    .instr_in  (bus.instr_in),
    .instr_out (bus.instr_out),
    .imm16     (bus.imm16),
    .rd        (bus.rd),
    .rt        (bus.rt),
    .rs        (bus.rs)
  );

  // Built from the registered IR, so a same-edge IR load never feeds the PC.
  concat u_concat (
    .pc_in       (bus.pc_in),
    .instr       (bus.instr_out),
    .jump_target (jump_target)
  );

  mux_pc_src u_mux (
    .sel         (bus.control_signal),
    .a_in        (bus.a_in),
    .alu_res_in  (bus.alu_res_in),
    .alu_in      (bus.alu_in),
    .jump_target (jump_target),
    .mux_out     (next_pc)
  );

  pc_register u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.pc_wren),
    .d     (next_pc),
    .q     (bus.output_word)
  );

endmodule

// File: tb/tb_ir_pc_next.sv
// tb/tb_ir_pc_next.sv - directed scoreboard bench for ir_pc_next
module tb_ir_pc_next;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_ir;
  logic [31:0] model_pc;

  ir_pc_next_if bus ();

  ir_pc_next dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [1:0] sel, input logic [31:0] pc,
                                             input logic [31:0] a, input logic [31:0] ar,
                                             input logic [31:0] al, input logic [31:0] ir);
    case (sel)
      2'd0:    return a;
      2'd1:    return ar;
      2'd2:    return al;
      default: return {pc[31:28], ir[25:0], 2'b00};
    endcase
  endfunction

  task automatic check_fields(input string tag, input logic [31:0] ir);
    chk({tag, "_ir"},  bus.instr_out, ir);
    chk({tag, "_imm"}, {16'h0, bus.imm16}, {16'h0, ir[15:0]});
    chk({tag, "_rd"},  {27'h0, bus.rd}, {27'h0, ir[15:11]});
    chk({tag, "_rt"},  {27'h0, bus.rt}, {27'h0, ir[20:16]});
    chk({tag, "_rs"},  {27'h0, bus.rs}, {27'h0, ir[25:21]});
  endtask

  task automatic step(input string tag, input logic iw, input logic pw, input logic [1:0] sel,
                      input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] a,
                      input logic [31:0] ar, input logic [31:0] al);
    exp_t e;
    @(negedge clk);
    bus.ir_we          = iw;
    bus.pc_wren        = pw;
    bus.control_signal = sel;
    bus.pc_in          = pc;
    bus.instr_in       = instr;
    bus.a_in           = a;
    bus.alu_res_in     = ar;
    bus.alu_in         = al;
    e.tag = tag;
    e.pc  = pw ? model_next(sel, pc, a, ar, al, model_ir) : model_pc;
    e.ir  = iw ? instr : model_ir;
    sb.push_back(e);
    #1;
    chk({tag, "_between"}, bus.output_word, model_pc);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "_pc"}, bus.output_word, e.pc);
    check_fields(e.tag, e.ir);
    model_pc = e.pc;
    model_ir = e.ir;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.ir_we          = 1'b1;
    bus.pc_wren        = 1'b1;
    bus.control_signal = 2'b11;
    bus.pc_in          = 32'h0;
    bus.instr_in       = 32'h0;
    bus.a_in           = 32'h0;
    bus.alu_res_in     = 32'h0;
    bus.alu_in         = 32'h0;
    model_ir           = 32'h0;
    model_pc           = 32'h0;

    #3;
    chk("reset_pc", bus.output_word, 32'h0);
    check_fields("reset", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Jump path: IR loads on edge 1, PC takes the target on edge 2.
    step("jmp_e1", 1'b1, 1'b1, 2'b11, 32'h0, 32'h07C1F07C, 32'h0, 32'h0, 32'h0);
    chk("jmp_e1_ir_const", bus.instr_out, 32'h07C1F07C);
    chk("jmp_e1_rs_const", {27'h0, bus.rs}, 32'h1E);
    chk("jmp_e1_rt_const", {27'h0, bus.rt}, 32'h01);
    chk("jmp_e1_rd_const", {27'h0, bus.rd}, 32'h1E);
    chk("jmp_e1_imm_const", {16'h0, bus.imm16}, 32'hF07C);
    step("jmp_e2", 1'b0, 1'b1, 2'b11, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    chk("jmp_e2_const", bus.output_word, 32'h0F07C1F0);

    step("pc_upper", 1'b0, 1'b1, 2'b11, 32'hA0000000, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("pc_upper_const", bus.output_word, 32'hAF07C1F0);

    step("sel_a",      1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333);
    chk("sel_a_const", bus.output_word, 32'h11111111);
    step("sel_alures", 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333);
    chk("sel_alures_const", bus.output_word, 32'h22222222);
    step("sel_alu",    1'b0, 1'b1, 2'b10, 32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333);
    chk("sel_alu_const", bus.output_word, 32'h33333333);

    step("hold1", 1'b0, 1'b0, 2'b00, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h44444444, 32'h55555555, 32'h66666666);
    step("hold2", 1'b0, 1'b0, 2'b11, 32'hF0000000, 32'h12345678, 32'h77777777, 32'h88888888, 32'h99999999);
    chk("hold_pc_const", bus.output_word, 32'h33333333);
    chk("hold_ir_const", bus.instr_out, 32'h07C1F07C);

    // Same-edge load: PC must use the IR contents from before this edge.
    step("simul", 1'b1, 1'b1, 2'b11, 32'h0, 32'h0BADF00D, 32'h0, 32'h0, 32'h0);
    chk("simul_pc_const", bus.output_word, 32'h0F07C1F0);
    step("simul_next", 1'b0, 1'b1, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("simul_next_const", bus.output_word, 32'h0EB7C034);

    // Asynchronous clear in the middle of a cycle, held across an enabled edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", bus.output_word, 32'h0);
    chk("midrst_ir", bus.instr_out, 32'h0);
    @(posedge clk);
    #1;
    chk("rsthold_pc", bus.output_word, 32'h0);
    model_pc = 32'h0;
    model_ir = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b1, 2'b00, 32'h0, 32'hCAFEF00D, 32'h13579BDF, 32'h0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      step("rand", 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
           $urandom, $urandom, $urandom);
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
